truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequential characterizer that drives a combinational truth-table module and reads its function back.
- Sweeps every input combination onto the DUT inputs in ascending order and waits a programmable settle time for each combination.
- Samples the DUT output and assembles a 2^N_IN-bit truth-table word, then compares it against an expected table.
- Sits in the verification/characterization path beside synthesized gate netlists and their truth-table models.

Parameters:
- N_IN, 3, number of DUT inputs; table width is 2^N_IN.
- SETTLE, 2, extra hold cycles per vector (0 allowed); each vector is held SETTLE+1 cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin scan; honoured only in IDLE.
- abort  input  1  synchronous scan cancel.
- expected  input  2^N_IN  reference table; bit k = required output for stimulus value k.
- stim  output  N_IN  DUT input vector; MSB maps to the DUT's first listed input.
- dut_out  input  1  DUT output being characterized.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when a scan completes.
- table_out  output  2^N_IN  last completed captured table.
- match  output  1  captured table equals latched expected table.
- mismatch_cnt  output  N_IN+1  popcount of (captured XOR expected).

Behaviour:
- Reset (async assert, sync release): state=IDLE; stim=0, busy=0, done=0, table_out=0, match=0, mismatch_cnt=0; work register and wait counter are 0.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE: start=1 at an edge moves to SCAN. In the same edge: busy=1, stim=0, wait_cnt=0, work=0, expected latched into exp_q. Later changes to expected have no effect on the scan.
- SCAN, each edge:
  - If wait_cnt==SETTLE: work[stim] <= dut_out.
  - If that sample was for stim==2^N_IN-1: go to DONE. Otherwise stim <= stim+1 and wait_cnt <= 0.
  - If wait_cnt<SETTLE: wait_cnt increments.
- stim is stable for exactly SETTLE+1 cycles per vector. No wrap occurs inside a scan.
- Entry to DONE, same edge as the last sample:
  - table_out <= final work including the last bit.
  - match <= (final work == exp_q).
  - mismatch_cnt <= popcount(final work ^ exp_q).
  - busy <= 0, done <= 1, stim <= 0.
- DONE lasts one cycle: done drops and the state returns to IDLE. start is ignored in DONE.
- Latency: the done-entry edge is 2^N_IN*(SETTLE+1) edges after the start-accept edge. Default is 24.
- start while busy: ignored, with no restart.
- abort=1 in SCAN: next state IDLE, busy=0, stim=0, no done pulse. table_out, match and mismatch_cnt keep their previous values.
- Priority in SCAN: abort beats the final sample. abort in IDLE or DONE has no effect.
- Reset mid-scan: immediate return to reset values. A partial table is never published.
- table_out, match and mismatch_cnt change only at done-entry edges or reset.
- wait_cnt width is max(1, clog2(SETTLE+1)).

Test Plan:
- DUT = out=1 only for {inp1,inp2,inp3}=3'b110, expected=8'h40, start pulse → done exactly 24 cycles after start-accept; table_out=8'h40, match=1, mismatch_cnt=0; stim steps 0..7, each held 3 cycles.
- Same DUT, expected=8'h41 → table_out=8'h40, match=0, mismatch_cnt=1. Changing expected to 8'h40 mid-scan leaves the result unchanged.
- After a completed 8'h40 scan, rerun with the DUT changed to constant 1 and assert abort at cycle 10 → busy=0 the next cycle, no done, table_out stays 8'h40. A new start then yields 8'hFF after 24 cycles.
- start pulses during SCAN and in the DONE cycle → ignored; exactly one done; no cycle-count shift.
- Assert rst_n low at cycle 12 of a scan → all outputs 0 immediately. After release, a full scan gives the correct table.
- N_IN=2, SETTLE=0, DUT=XOR → table_out=4'b0110 after 4 cycles. A DUT with 2-cycle registered latency gives a correct table with SETTLE=2 and an incorrect table with SETTLE=0.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Characterizes a combinational block by sweeping every input value onto
//   `stim` in ascending order and holding each one for SETTLE+1 cycles. The
//   block's response `dut_out` is sampled on the last cycle of each hold. The
//   samples are assembled into a 2^N_IN-bit table (bit k = response to value k),
//   and that table is compared against a reference latched when the scan starts.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin a scan (accepted only while idle)
//   abort         cancel a running scan; published results are kept
//   expected      reference table, latched at scan start
//   stim          stimulus vector (MSB = first listed input of the target)
//   dut_out       response of the block under characterization
//   busy          scan in progress
//   done          one-cycle pulse when a scan completes
//   table_out     last completed captured table
//   match         captured table == latched reference
//   mismatch_cnt  number of differing table bits
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN:0]          mismatch_cnt
);

  localparam int TW  = 1 << N_IN;
  localparam int CW  = N_IN + 1;
  localparam int WCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(SETTLE);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [TW-1:0]     work_q, work_d;
  logic [TW-1:0]     exp_q, exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TW-1:0]     table_q, table_d;
  logic              match_q, match_d;
  logic [CW-1:0]     mcnt_q, mcnt_d;

  // Sample point of the current vector, and whether it is the final vector.
  logic              sample;
  logic              last;
  logic [TW-1:0]     work_nx;
  logic [TW-1:0]     diff;
  logic [CW-1:0]     pop;

  assign sample = (state_q == SCAN) && (wait_q == WAIT_LAST);
  assign last   = sample && (stim_q == STIM_LAST);

  // Work table including the bit captured this cycle, so the result
  // published on the final edge already contains the last sample.
  always_comb begin
    work_nx = work_q;
    if (sample) work_nx[stim_q] = dut_out;
  end

  always_comb begin
    diff = work_nx ^ exp_q;
    pop  = '0;
    for (int i = 0; i < TW; i++) pop = pop + CW'(diff[i]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      wait_q  <= '0;
      work_q  <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      match_q <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      wait_q  <= wait_d;
      work_q  <= work_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      match_q <= match_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next-state logic; abort outranks the final sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / registered outputs
  always_comb begin
    stim_d  = stim_q;
    wait_d  = wait_q;
    work_d  = work_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    match_d = match_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          stim_d = '0;
          wait_d = '0;
          work_d = '0;
          exp_d  = expected;
        end
      end
      SCAN: begin
        if (abort) begin
          busy_d = 1'b0;
          stim_d = '0;
          wait_d = '0;
        end else if (sample) begin
          work_d = work_nx;
          wait_d = '0;
          if (last) begin
            table_d = work_nx;
            match_d = (work_nx == exp_q);
            mcnt_d  = pop;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
          end else begin
            stim_d = stim_q + N_IN'(1);
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: ;
    endcase
  end

  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign match        = match_q;
  assign mismatch_cnt = mcnt_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: stimulus pushes the expected result of each scan that must
// complete; per-instance monitors pop and compare whenever done is seen.
module tb_truth_table_scanner;

  typedef struct {
    logic [7:0] tbl;
    logic       m;
    logic [3:0] cnt;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, abort, start2;
  logic [7:0] expected;
  logic [3:0] exp2;
  int   mode0, cyc, pass_cnt, total_cnt;
  logic mode_s;

  // Main instance: 3 inputs, SETTLE=2
  logic [2:0] stim0;
  logic       dut0, busy0, done0, match0;
  logic [7:0] tbl0;
  logic [3:0] cnt0;

  // Small instances: 2 inputs, SETTLE=0 and SETTLE=2
  logic [1:0] stim1, stim2;
  logic       dut1, dut2, busy1, busy2, done1, done2, match1, match2;
  logic [3:0] tbl1, tbl2;
  logic [2:0] cnt1, cnt2;
  logic       p1a = 1'b0, p1b = 1'b0, p2a = 1'b0, p2b = 1'b0;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Target functions: one-hot at 3'b110 or constant 1; 2-input XOR, direct
  // or behind a two-register pipeline.
  assign dut0 = (mode0 == 1) ? 1'b1 : (stim0 == 3'b110);
  always @(posedge clk) begin
    p1a <= ^stim1; p1b <= p1a;
    p2a <= ^stim2; p2b <= p2a;
  end
  assign dut1 = mode_s ? p1b : ^stim1;
  assign dut2 = p2b;

  truth_table_scanner #(.N_IN(3), .SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .stim(stim0), .dut_out(dut0), .busy(busy0), .done(done0), .table_out(tbl0),
    .match(match0), .mismatch_cnt(cnt0));

  truth_table_scanner #(.N_IN(2), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .expected(exp2),
    .stim(stim1), .dut_out(dut1), .busy(busy1), .done(done1), .table_out(tbl1),
    .match(match1), .mismatch_cnt(cnt1));

  truth_table_scanner #(.N_IN(2), .SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .expected(exp2),
    .stim(stim2), .dut_out(dut2), .busy(busy2), .done(done2), .table_out(tbl2),
    .match(match2), .mismatch_cnt(cnt2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic unexpected(input string nm);
    total_cnt++;
    $display("FAIL %s_unexpected_done: got done=1 expected no pending scan (t=%0t)", nm, $time);
  endtask

  task automatic score(input string nm, input exp_t e, input logic [7:0] t,
                       input logic m, input logic [3:0] c);
    chk({nm, "_table"},   32'(t), 32'(e.tbl));
    chk({nm, "_match"},   32'(m), 32'(e.m));
    chk({nm, "_mcnt"},    32'(c), 32'(e.cnt));
    chk({nm, "_latency"}, 32'(cyc), 32'(e.due));
  endtask

  // Monitors
  always @(negedge clk) if (rst_n && done0) begin
    if (q0.size() == 0) unexpected("u0");
    else begin e0 = q0.pop_front(); score("u0", e0, tbl0, match0, cnt0); end
  end
  always @(negedge clk) if (rst_n && done1) begin
    if (q1.size() == 0) unexpected("u1");
    else begin e1 = q1.pop_front(); score("u1", e1, {4'b0, tbl1}, match1, {1'b0, cnt1}); end
  end
  always @(negedge clk) if (rst_n && done2) begin
    if (q2.size() == 0) unexpected("u2");
    else begin e2 = q2.pop_front(); score("u2", e2, {4'b0, tbl2}, match2, {1'b0, cnt2}); end
  end

  // Start a main scan; returns at the negedge right after the accept edge.
  task automatic do_scan(input logic [7:0] e, input logic [7:0] want, input logic m,
                         input logic [3:0] c, input bit push);
    exp_t x;
    @(negedge clk);
    expected = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      x.tbl = want; x.m = m; x.cnt = c; x.due = cyc + 24;
      q0.push_back(x);
    end
  endtask

  task automatic wait_idle0();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy0) begin ok = 1; break; end
    end
    if (!ok) chk("u0_idle_timeout", 32'(busy0), 32'd0);
  endtask

  task automatic small_scan(input logic [3:0] w1, input logic m1, input logic [3:0] c1);
    exp_t x;
    bit ok;
    @(negedge clk);
    exp2 = 4'b0110;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    x.tbl = {4'b0, w1}; x.m = m1; x.cnt = c1; x.due = cyc + 4;
    q1.push_back(x);
    x.tbl = 8'h06; x.m = 1'b1; x.cnt = 4'd0; x.due = cyc + 12;
    q2.push_back(x);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy2 && !busy1) begin ok = 1; break; end
    end
    if (!ok) chk("small_idle_timeout", 32'(busy2), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    cyc = 0; pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
    expected = 8'h00; exp2 = 4'h0; mode0 = 0; mode_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim", 32'(stim0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_table", 32'(tbl0), 32'd0);
    chk("rst_mcnt", 32'(cnt0), 32'd0);
    rst_n = 1'b1;

    // Matching scan; stim steps 0..7, three cycles each
    do_scan(8'h40, 8'h40, 1'b1, 4'd0, 1);
    for (int j = 0; j < 24; j++) begin
      chk($sformatf("stim_j%0d", j), 32'(stim0), 32'(j / 3));
      if (j == 0) chk("busy_after_accept", 32'(busy0), 32'd1);
      @(negedge clk);
    end
    wait_idle0();

    // One-bit mismatch; reference change mid-scan must not matter
    do_scan(8'h41, 8'h40, 1'b0, 4'd1, 1);
    repeat (5) @(negedge clk);
    expected = 8'h40;
    wait_idle0();

    // Abort on cycle 10 of a constant-1 scan: no done, results kept
    mode0 = 1;
    do_scan(8'hFF, 8'hFF, 1'b1, 4'd0, 0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_stim", 32'(stim0), 32'd0);
    chk("abort_table", 32'(tbl0), 32'h40);
    chk("abort_match", 32'(match0), 32'd0);
    chk("abort_mcnt", 32'(cnt0), 32'd1);
    repeat (30) @(negedge clk);
    do_scan(8'hFF, 8'hFF, 1'b1, 4'd0, 1);
    wait_idle0();

    // start pulses during SCAN and in the DONE cycle are ignored
    do_scan(8'hFF, 8'hFF, 1'b1, 4'd0, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 32'(done0), 32'd1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_in_done_busy", 32'(busy0), 32'd0);
    repeat (30) @(negedge clk);

    // Reset mid-scan clears everything at once
    mode0 = 0;
    do_scan(8'h40, 8'h40, 1'b1, 4'd0, 0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stim", 32'(stim0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_table", 32'(tbl0), 32'd0);
    chk("mid_rst_match", 32'(match0), 32'd0);
    chk("mid_rst_mcnt", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_scan(8'h40, 8'h40, 1'b1, 4'd0, 1);
    wait_idle0();

    // 2-input XOR: direct with SETTLE=0, then two-cycle latency target.
    // With SETTLE=0 each sample sees the response to the vector two steps
    // earlier: bits 0..2 read xor(0)=0, bit 3 reads xor(1)=1 -> 4'b1000.
    mode_s = 1'b0;
    small_scan(4'b0110, 1'b1, 4'd0);
    mode_s = 1'b1;
    repeat (4) @(negedge clk);
    small_scan(4'b1000, 1'b0, 4'd3);

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
